// File: rtl/count_divider_mc.sv
// count_divider_mc: independent per-channel programmable clock dividers with toggle or pulse output
module count_divider_mc #(
  parameter int WIDTH    = 7,
  parameter int CHANNELS = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*WIDTH-1:0] period,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       result
);
  typedef enum logic {IDLE, RUN} state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] p;
    logic             tc_r;
    logic             res_r;

    assign p = period[c*WIDTH +: WIDTH];
    assign count[c*WIDTH +: WIDTH] = cnt;
    assign tc[c] = tc_r;
    assign result[c] = res_r;

    // Channel FSM: load restarts from the live period; a zero count reloads from the live period and fires tc
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state  <= IDLE;
        cnt    <= '0;
        shadow <= '0;
        tc_r   <= 1'b0;
        res_r  <= 1'b0;
      end else if (load[c]) begin
        state  <= RUN;
        cnt    <= p;
        shadow <= p;
        tc_r   <= 1'b0;
      end else if (state == RUN) begin
        if (!enable[c]) begin
          tc_r <= 1'b0;
        end else if (cnt == '0) begin
          cnt    <= p;
          shadow <= p;
          tc_r   <= 1'b1;
          res_r  <= mode[c] ? 1'b1 : ~res_r;
        end else begin
          cnt   <= cnt - 1'b1;
          tc_r  <= 1'b0;
          res_r <= mode[c] ? 1'b0 : res_r;
        end
      end
    end

    // The running count never exceeds the period it was started from
    a_bound: assert property (@(posedge clock) disable iff (!reset_n) cnt <= shadow);
  end
endmodule

// File: tb/tb_count_divider_mc.sv
// tb_count_divider_mc: directed vector table plus multi-cycle sequences for count_divider_mc
module tb_count_divider_mc;
  localparam int W = 7;
  localparam int C = 2;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [C-1:0]   load, enable, mode;
  logic [C*W-1:0] period, count;
  logic [C-1:0]   tc, result;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       ld, en, md;
    logic [6:0] p, ec;
    logic       etc, er;
  } vec_t;
  vec_t vt[13];

  always #5 clock = ~clock;

  count_divider_mc #(.WIDTH(W), .CHANNELS(C)) dut (
    .clock(clock), .reset_n(reset_n), .load(load), .enable(enable), .mode(mode),
    .period(period), .count(count), .tc(tc), .result(result)
  );

  function automatic vec_t mk(input logic ld, en, md, input logic [6:0] p, ec, input logic et, er);
    vec_t v;
    v.ld = ld; v.en = en; v.md = md; v.p = p; v.ec = ec; v.etc = et; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cnt(input int c);
    return int'(count[c*W +: W]);
  endfunction

  task automatic set_p(input int c, input int v);
    period[c*W +: W] = 7'(v);
  endtask

  task automatic chk_ch(input string tag, input int c, input int ec, input int et, input int er);
    check({tag, "_count"}, cnt(c), ec);
    check({tag, "_tc"}, int'(tc[c]), et);
    check({tag, "_result"}, int'(result[c]), er);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    load = '0; enable = '0; mode = '0; period = '0;
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    int bad;
    vt[0]  = mk(0, 1, 0, 2, 0, 0, 0);
    vt[1]  = mk(1, 0, 0, 2, 2, 0, 0);
    vt[2]  = mk(0, 1, 0, 2, 1, 0, 0);
    vt[3]  = mk(0, 1, 0, 2, 0, 0, 0);
    vt[4]  = mk(0, 1, 0, 2, 2, 1, 1);
    vt[5]  = mk(0, 1, 0, 2, 1, 0, 1);
    vt[6]  = mk(0, 0, 0, 2, 1, 0, 1);
    vt[7]  = mk(0, 1, 0, 2, 0, 0, 1);
    vt[8]  = mk(0, 1, 1, 2, 2, 1, 1);
    vt[9]  = mk(0, 1, 1, 2, 1, 0, 0);
    vt[10] = mk(0, 1, 0, 5, 0, 0, 0);
    vt[11] = mk(0, 1, 0, 5, 5, 1, 1);
    vt[12] = mk(1, 1, 0, 3, 3, 0, 1);

    reset_n = 1'b0; load = '0; enable = '0; mode = '0; period = '0;
    #2;
    chk_ch("reset0", 0, 0, 0, 0);
    chk_ch("reset1", 1, 0, 0, 0);
    #1 reset_n = 1'b1;
    step;
    chk_ch("idle", 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      load[0] = vt[i].ld; enable[0] = vt[i].en; mode[0] = vt[i].md;
      set_p(0, int'(vt[i].p));
      step;
      chk_ch($sformatf("vec%0d", i), 0, int'(vt[i].ec), int'(vt[i].etc), int'(vt[i].er));
      check($sformatf("vec%0d_ch1_count", i), cnt(1), 0);
    end

    // toggle mode, P=7
    do_reset;
    set_p(0, 7); load[0] = 1'b1; enable[0] = 1'b1;
    step;
    chk_ch("s1_load", 0, 7, 0, 0);
    load[0] = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step;
      chk_ch($sformatf("s1_k%0d", k), 0, (k % 8 == 0) ? 7 : 7 - k % 8, int'(k % 8 == 0), (k / 8) % 2);
    end

    // ch1 pulse mode P=0 alongside ch0 toggle P=3
    do_reset;
    mode = 2'b10; set_p(0, 3); set_p(1, 0); load = 2'b11; enable = 2'b11;
    step;
    chk_ch("s2_load0", 0, 3, 0, 0);
    chk_ch("s2_load1", 1, 0, 0, 0);
    load = 2'b00;
    for (int k = 1; k <= 16; k++) begin
      step;
      chk_ch($sformatf("s2_ch1_k%0d", k), 1, 0, 1, 1);
      chk_ch($sformatf("s2_ch0_k%0d", k), 0, (k % 4 == 0) ? 3 : 3 - k % 4, int'(k % 4 == 0), (k / 4) % 2);
    end

    // period change mid-count
    do_reset;
    set_p(0, 7); load[0] = 1'b1; enable[0] = 1'b1;
    step;
    load[0] = 1'b0;
    step; step;
    check("s3_at5", cnt(0), 5);
    set_p(0, 3);
    for (int k = 3; k <= 7; k++) begin
      step;
      check($sformatf("s3_k%0d_count", k), cnt(0), 7 - k);
      check($sformatf("s3_k%0d_tc", k), int'(tc[0]), 0);
    end
    for (int k = 8; k <= 20; k++) begin
      step;
      check($sformatf("s3_k%0d_count", k), cnt(0), ((k - 8) % 4 == 0) ? 3 : 3 - (k - 8) % 4);
      check($sformatf("s3_k%0d_tc", k), int'(tc[0]), int'((k - 8) % 4 == 0));
    end

    // load on the terminal cycle
    do_reset;
    set_p(0, 2); load[0] = 1'b1; enable[0] = 1'b1;
    step;
    load[0] = 1'b0;
    step; step; step;
    chk_ch("s4_tc", 0, 2, 1, 1);
    step; step;
    chk_ch("s4_zero", 0, 0, 0, 1);
    load[0] = 1'b1; set_p(0, 5);
    step;
    chk_ch("s4_load", 0, 5, 0, 1);
    load[0] = 1'b0;

    // enable gap at count 4
    do_reset;
    set_p(0, 7); load[0] = 1'b1; enable[0] = 1'b1;
    step;
    load[0] = 1'b0;
    step; step; step;
    check("s5_at4", cnt(0), 4);
    enable[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step;
      chk_ch($sformatf("s5_hold%0d", k), 0, 4, 0, 0);
    end
    enable[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step;
      check($sformatf("s5_run%0d_count", k), cnt(0), 4 - k);
      check($sformatf("s5_run%0d_tc", k), int'(tc[0]), 0);
    end
    step;
    chk_ch("s5_tc", 0, 7, 1, 1);

    // asynchronous reset mid-run with result high
    do_reset;
    set_p(0, 1); load[0] = 1'b1; enable[0] = 1'b1;
    step;
    load[0] = 1'b0;
    step; step;
    chk_ch("s6_pre", 0, 1, 1, 1);
    #2 reset_n = 1'b0;
    #1;
    chk_ch("s6_async", 0, 0, 0, 0);
    #1 reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      step;
      if (tc != '0 || result != '0 || count != '0) bad++;
    end
    check("s6_idle_300", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
